// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch traceback writer and reader:
// step encodings, reader FSM states and default geometry.
package nw_pkg;

    localparam int NW_LENGTH      = 10;
    localparam int NW_CWIDTH      = 2;
    localparam int NW_CORD_LENGTH = 8;
    localparam int NW_MEM_SIZE    = 9;

    typedef enum logic [1:0] {
        OP_MATCH    = 2'b00,
        OP_MISMATCH = 2'b01,
        OP_INS      = 2'b10,
        OP_DEL      = 2'b11
    } nw_op_e;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_FETCH,
        RD_WAIT,
        RD_EMIT,
        RD_DONE,
        RD_ERR
    } rd_state_e;

endpackage

// File: rtl/nw_step_decode.sv
// Classifies one traceback step from the previous to the current coordinate
// and picks the characters involved; bad flags any step the path cannot take.
module nw_step_decode
    import nw_pkg::*;
#(
    parameter int LENGTH      = NW_LENGTH,
    parameter int CWIDTH      = NW_CWIDTH,
    parameter int CORD_LENGTH = NW_CORD_LENGTH
) (
    input  logic                     first,
    input  logic [CORD_LENGTH-1:0]   prev_x,
    input  logic [CORD_LENGTH-1:0]   prev_y,
    input  logic [CORD_LENGTH-1:0]   cur_x,
    input  logic [CORD_LENGTH-1:0]   cur_y,
    input  logic [LENGTH*CWIDTH-1:0] s1,
    input  logic [LENGTH*CWIDTH-1:0] s2,
    output logic [1:0]               op,
    output logic [CWIDTH-1:0]        c1,
    output logic [CWIDTH-1:0]        c2,
    output logic                     bad
);

    logic [CORD_LENGTH-1:0] dx, dy;
    logic [CWIDTH-1:0]      ch1, ch2;
    logic                   in_x, in_y;
    logic                   diag, ins, del;

    assign dx = cur_x - prev_x;
    assign dy = cur_y - prev_y;

    // The first entry is a diagonal step from a virtual (-1,-1), so it must be (0,0).
    assign diag = first ? (cur_x == '0 && cur_y == '0)
                        : (dx == CORD_LENGTH'(1) && dy == CORD_LENGTH'(1));
    assign ins  = !first && dx == CORD_LENGTH'(1) && dy == '0;
    assign del  = !first && dx == '0 && dy == CORD_LENGTH'(1);

    always_comb begin
        ch1  = '0;
        ch2  = '0;
        in_x = 1'b0;
        in_y = 1'b0;
        for (int i = 0; i < LENGTH; i++) begin
            if (cur_y == CORD_LENGTH'(i)) begin
                ch1  = s1[i*CWIDTH +: CWIDTH];
                in_y = 1'b1;
            end
            if (cur_x == CORD_LENGTH'(i)) begin
                ch2  = s2[i*CWIDTH +: CWIDTH];
                in_x = 1'b1;
            end
        end
    end

    always_comb begin
        op  = OP_MATCH;
        c1  = '0;
        c2  = '0;
        bad = 1'b0;
        if (!in_x || !in_y) begin
            bad = 1'b1;
        end else if (diag) begin
            op = (ch1 == ch2) ? OP_MATCH : OP_MISMATCH;
            c1 = ch1;
            c2 = ch2;
        end else if (ins) begin
            op = OP_INS;
            c2 = ch2;
        end else if (del) begin
            op = OP_DEL;
            c1 = ch1;
        end else begin
            bad = 1'b1;
        end
    end

endmodule

// File: rtl/nw_align_reader.sv
// Replays a stored traceback path (written end-to-start) as a forward stream
// of alignment steps over a valid/ready handshake.
module nw_align_reader
    import nw_pkg::*;
#(
    parameter int LENGTH      = NW_LENGTH,
    parameter int CWIDTH      = NW_CWIDTH,
    parameter int CORD_LENGTH = NW_CORD_LENGTH,
    parameter int MEM_SIZE    = NW_MEM_SIZE,
    parameter int BYTE_SIZE   = 2*CORD_LENGTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [MEM_SIZE-1:0]      count,
    input  logic [LENGTH*CWIDTH-1:0] s1,
    input  logic [LENGTH*CWIDTH-1:0] s2,
    output logic [MEM_SIZE-1:0]      raddr,
    input  logic [BYTE_SIZE-1:0]     rdata,
    output logic [1:0]               op,
    output logic [CWIDTH-1:0]        c1,
    output logic [CWIDTH-1:0]        c2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int MAX_COUNT = 2*LENGTH - 1;

    rd_state_e              state, next_state;
    logic [MEM_SIZE-1:0]    addr;
    logic [CORD_LENGTH-1:0] prev_x, prev_y, cur_x, cur_y;
    logic                   first;
    logic [1:0]             dec_op;
    logic [CWIDTH-1:0]      dec_c1, dec_c2;
    logic                   dec_bad;
    logic                   count_bad, at_end, end_bad;

    assign cur_x     = rdata[BYTE_SIZE-1 -: CORD_LENGTH];
    assign cur_y     = rdata[CORD_LENGTH-1:0];
    assign count_bad = (count == '0) || (int'(count) > MAX_COUNT);
    assign at_end    = (addr == '0);
    // Address 0 holds the entry the writer stored first: the far corner.
    assign end_bad   = at_end && (cur_x != CORD_LENGTH'(LENGTH-1) ||
                                  cur_y != CORD_LENGTH'(LENGTH-1));
    assign raddr     = addr;

    nw_step_decode #(
        .LENGTH      (LENGTH),
        .CWIDTH      (CWIDTH),
        .CORD_LENGTH (CORD_LENGTH)
    ) u_dec (
        .first  (first),
        .prev_x (prev_x),
        .prev_y (prev_y),
        .cur_x  (cur_x),
        .cur_y  (cur_y),
        .s1     (s1),
        .s2     (s2),
        .op     (dec_op),
        .c1     (dec_c1),
        .c2     (dec_c2),
        .bad    (dec_bad)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RD_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            RD_IDLE:  if (start) next_state = count_bad ? RD_ERR : RD_FETCH;
            RD_FETCH: next_state = RD_WAIT;
            RD_WAIT:  next_state = (dec_bad || end_bad) ? RD_ERR : RD_EMIT;
            RD_EMIT:  if (out_ready) next_state = at_end ? RD_DONE : RD_FETCH;
            RD_DONE:  next_state = RD_IDLE;
            RD_ERR:   next_state = RD_IDLE;
            default:  next_state = RD_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != RD_IDLE);
        out_valid = (state == RD_EMIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr   <= '0;
            prev_x <= '0;
            prev_y <= '0;
            first  <= 1'b0;
            op     <= OP_MATCH;
            c1     <= '0;
            c2     <= '0;
            done   <= 1'b0;
            error  <= 1'b0;
        end else begin
            case (state)
                RD_IDLE: if (start) begin
                    done  <= 1'b0;
                    error <= 1'b0;
                    first <= 1'b1;
                    addr  <= count_bad ? '0 : count - MEM_SIZE'(1);
                end
                RD_WAIT: if (next_state == RD_EMIT) begin
                    op     <= dec_op;
                    c1     <= dec_c1;
                    c2     <= dec_c2;
                    prev_x <= cur_x;
                    prev_y <= cur_y;
                    first  <= 1'b0;
                end
                RD_EMIT: if (out_ready && !at_end) addr <= addr - MEM_SIZE'(1);
                RD_DONE: done  <= 1'b1;
                RD_ERR:  error <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
